// File: rtl/da_fir_ctrl.sv
// Bit-serial distributed-arithmetic FIR sequencer: sample delay line, MSB-first bit-plane
// ROM addressing, and shift-and-add accumulation of the ROM partial sums.
module da_fir_ctrl #(
    parameter int TAPS      = 7,
    parameter int DATA_W    = 8,
    parameter int OPSIZE    = 12,
    parameter int ADDR_SIZE = 8,
    parameter int ACC_W     = OPSIZE + DATA_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [DATA_W-1:0]    i_sample,
    output logic                 o_ready,
    output logic                 o_rom_oe,
    output logic [ADDR_SIZE-1:0] o_rom_addr,
    input  logic [OPSIZE-1:0]    i_rom_data,
    output logic                 o_valid,
    output logic [ACC_W-1:0]     o_result,
    output logic                 o_busy
);
    localparam int KW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [KW-1:0] K_MSB = KW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        state_q, state_d;
    logic [TAPS-1:0][DATA_W-1:0]   taps_q, taps_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [ACC_W-1:0]              acc_q, acc_d;
    logic [ACC_W-1:0]              rom_sx;
    logic                          ready_q, ready_d;
    logic                          oe_q, oe_d;
    logic [ADDR_SIZE-1:0]          addr_q, addr_d;
    logic                          valid_q, valid_d;
    logic [ACC_W-1:0]              result_q, result_d;
    logic                          busy_q, busy_d;

    assign rom_sx = {{(ACC_W-OPSIZE){i_rom_data[OPSIZE-1]}}, i_rom_data};

    always_comb begin
        state_d  = state_q;
        taps_d   = taps_q;
        k_d      = k_q;
        acc_d    = acc_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    taps_d[0] = i_sample;
                    for (int t = 1; t < TAPS; t++) taps_d[t] = taps_q[t-1];
                    k_d     = K_MSB;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The sign bit-plane carries negative weight in two's complement.
                if (k_q == K_MSB) acc_d = -rom_sx;
                else              acc_d = {acc_q[ACC_W-2:0], 1'b0} + rom_sx;
                if (k_q == '0) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = acc_d;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state and next bit index.
        addr_d = '0;
        if (state_d == RUN) begin
            for (int t = 0; t < TAPS; t++) addr_d[t] = taps_d[t][k_d];
        end
        oe_d    = (state_d == RUN);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            taps_q   <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            ready_q  <= 1'b0;
            oe_q     <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            taps_q   <= taps_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            ready_q  <= ready_d;
            oe_q     <= oe_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_rom_oe   = oe_q;
    assign o_rom_addr = addr_q;
    assign o_valid    = valid_q;
    assign o_result   = result_q;
    assign o_busy     = busy_q;
endmodule
